gf_syndrome: RTL and testbench

GF_SYNDROME -- requirements
Module: gf_syndrome

---
 rtl/gf_syndrome.sv | 126 ++++++++++++
 tb/tb_gf_syndrome.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf_syndrome.sv
// GF(m+1) syndrome generator: Horner evaluation of r(x) at alpha^1..alpha^T.
// Optional err_free output enabled by defining GF_SYN_ERRFREE_EN.
module gf_syndrome #(
    parameter int m         = 255,
    parameter int SIZE      = $clog2(m),
    parameter int n         = 2,
    parameter int T         = 2,
    parameter int PRIM      = 9'h11D,
    parameter int flat_size = (n + 1) * SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [flat_size-1:0] flat_r,
    output logic                 busy,
    output logic                 done,
`ifdef GF_SYN_ERRFREE_EN
    output logic                 err_free,
`endif
    output logic [T*SIZE-1:0]    flat_s
);

    localparam int IW = (n > 0) ? $clog2(n + 1) : 1;
    localparam logic [SIZE-1:0] POLY = SIZE'(PRIM);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [SIZE-1:0] gf_mul(
        input logic [SIZE-1:0] a,
        input logic [SIZE-1:0] b
    );
        logic [SIZE-1:0] p;
        logic [SIZE-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) p = p ^ x;
            x = x[SIZE-1] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [SIZE-1:0] gf_pow(input int e);
        logic [SIZE-1:0] p;
        p = SIZE'(1);
        for (int i = 0; i < e; i++) p = gf_mul(p, SIZE'(2));
        return p;
    endfunction

    state_t                 state;
    logic [flat_size-1:0]   r_q;
    logic [IW-1:0]          idx;
    logic [T-1:0][SIZE-1:0] acc;
    logic [T-1:0][SIZE-1:0] acc_nxt;
    logic [SIZE-1:0]        coeff;

    assign coeff = r_q[idx*SIZE +: SIZE];

    // One Horner step per syndrome, each against its own constant alpha^j
    for (genvar j = 0; j < T; j++) begin : g_step
        localparam logic [SIZE-1:0] AJ = gf_pow(j + 1);
        assign acc_nxt[j] = gf_mul(acc[j], AJ) ^ coeff;
    end

    // Control FSM with capture, accumulation and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r_q    <= '0;
            idx    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            flat_s <= '0;
`ifdef GF_SYN_ERRFREE_EN
            err_free <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        r_q   <= flat_r;
                        acc   <= '0;
                        idx   <= IW'(n);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        flat_s <= acc_nxt;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef GF_SYN_ERRFREE_EN
                        err_free <= (acc_nxt == '0);
`endif
                    end
                end
                DONE: begin
                    // Allows back-to-back runs when start is held high
                    if (start) begin
                        r_q   <= flat_r;
                        acc   <= '0;
                        idx   <= IW'(n);
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_syndrome.sv
// Self-checking bench for gf_syndrome (defaults m=255, n=2, T=2).
// Table vectors, random vectors vs. a power-sum model, reset and back-to-back runs.
module tb_gf_syndrome;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] flat_r;
    logic        busy;
    logic        done;
    logic [15:0] flat_s;
`ifdef GF_SYN_ERRFREE_EN
    logic        err_free;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] sbq[$];

    gf_syndrome dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flat_r (flat_r),
        .busy   (busy),
        .done   (done),
`ifdef GF_SYN_ERRFREE_EN
        .err_free (err_free),
`endif
        .flat_s (flat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] r;
        logic [15:0] s;
        logic        ef;
    } vec_t;

    vec_t tbl[5];

    // Reference: carry-less product then long-division reduction by 0x11D
    function automatic logic [7:0] mdl_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11D << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] mdl_pow(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < e; i++) p = mdl_mul(p, 8'h02);
        return p;
    endfunction

    // S_j = sum_i r_i * alpha^(i*j)
    function automatic logic [15:0] mdl_syn(input logic [23:0] r);
        logic [7:0] s [2];
        logic [7:0] ri;
        for (int j = 0; j < 2; j++) begin
            s[j] = '0;
            for (int i = 0; i < 3; i++) begin
                ri = r[i*8 +: 8];
                s[j] = s[j] ^ mdl_mul(ri, mdl_pow(i * (j + 1)));
            end
        end
        return {s[1], s[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(
        input logic [23:0] r,
        input logic [15:0] exp,
        input logic        ef,
        input bit          perturb,
        input string       nm
    );
        int cyc;
        bit got;
        logic [15:0] e;
        @(negedge clk);
        flat_r = r;
        start  = 1'b1;
        sbq.push_back(exp);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            start = perturb && (cyc == 1);
            if (perturb && cyc == 1) flat_r = ~r;
            if (done) got = 1;
        end
        start = 1'b0;
        chk({nm, "_latency"}, got ? cyc : 99, 4);
        e = sbq.pop_front();
        if (got) begin
            chk({nm, "_flat_s"}, 32'(flat_s), 32'(e));
`ifdef GF_SYN_ERRFREE_EN
            chk({nm, "_err_free"}, 32'(err_free), 32'(ef));
`else
            if (ef !== ef) $display("unreachable");
`endif
            @(negedge clk);
            chk({nm, "_done_pulse"}, 32'(done), 0);
            chk({nm, "_idle"}, 32'(busy), 0);
            chk({nm, "_hold"}, 32'(flat_s), 32'(e));
        end
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        bit saw;
        logic [23:0] rr;
        logic [15:0] e;

        tbl[0] = '{24'h040105, 16'h4117, 1'b0};
        tbl[1] = '{24'h000000, 16'h0000, 1'b1};
        tbl[2] = '{24'h000001, 16'h0101, 1'b0};
        tbl[3] = '{24'h010000, 16'h1004, 1'b0};
        tbl[4] = '{24'h000100, 16'h0402, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        flat_r = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_flat_s", 32'(flat_s), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        for (int k = 0; k < 5; k++)
            run_vec(tbl[k].r, tbl[k].s, tbl[k].ef, 1'b0, $sformatf("tbl%0d", k));

        run_vec(24'h010000, 16'h1004, 1'b0, 1'b1, "ignore_run");

        // Reset during the second RUN cycle
        @(negedge clk);
        flat_r = 24'h040105;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_flat_s", 32'(flat_s), 0);
        saw = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("midrst_no_done", 32'(saw), 0);
        chk("midrst_flat_s_after", 32'(flat_s), 0);
        run_vec(24'h040105, 16'h4117, 1'b0, 1'b0, "after_rst");

        // Back-to-back with start held high
        @(negedge clk);
        flat_r = 24'h040105;
        start  = 1'b1;
        sbq.push_back(16'h4117);
        sbq.push_back(16'h4117);
        t1 = -1;
        t2 = -1;
        cyc = 0;
        while (cyc < 30 && t2 < 0) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = sbq.pop_front();
                chk("b2b_flat_s", 32'(flat_s), 32'(e));
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_first_lat", 32'(t1), 4);
        chk("b2b_spacing", 32'(t2 - t1), 4);
        cyc = 0;
        while (cyc < 10 && busy) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_back_idle", 32'(busy), 0);
        sbq.delete();

        // Random vectors against the power-sum model
        for (int k = 0; k < 6; k++) begin
            rr = 24'($urandom);
            e  = mdl_syn(rr);
            run_vec(rr, e, (e == 16'h0), 1'b0, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
